s27_bist_sequencer: RTL and testbench

- Built-in self-test controller that sequences the s27 benchmark datapath for trojan detection.
- Flushes the s27 flip-flops to a known state, then drives G0..G3 with an LFSR pattern stream.
- Compacts every G17 response into a 16-bit MISR signature and compares it against a golden signature from a trojan-free netlist.
- Sits beside the s27 instance: its outputs drive the s27 primary inputs, and s27 G17 feeds back into it.

---
 rtl/s27_bist_sequencer_if.sv | 39 +++
 rtl/s27_bist_sequencer.sv | 141 ++++++++++++++
 tb/tb_s27_bist_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s27_bist_sequencer_if.sv
// s27_bist_sequencer_if
//   Groups the control, stimulus and result signals exchanged between the
//   s27 BIST sequencer and its environment (host plus s27 instance).
//
//   START       host -> seq   begin a run (sampled only while idle)
//   PAT_COUNT   host -> seq   number of captured patterns, latched at START
//   GOLDEN_SIG  host -> seq   expected signature, latched at START
//   G17         s27  -> seq   s27 response bit
//   DUT_G0..3   seq  -> s27   registered stimulus to s27 primary inputs
//   BUSY        seq  -> host  high while flushing or running patterns
//   DONE        seq  -> host  one-cycle end-of-run pulse
//   SIG         seq  -> host  current / final MISR signature
//   MISMATCH    seq  -> host  final signature differs from golden
//
//   master: the sequencer side.  slave: the host / s27 side.
interface s27_bist_sequencer_if;
    logic        START;
    logic [15:0] PAT_COUNT;
    logic [15:0] GOLDEN_SIG;
    logic        G17;
    logic        DUT_G0;
    logic        DUT_G1;
    logic        DUT_G2;
    logic        DUT_G3;
    logic        BUSY;
    logic        DONE;
    logic [15:0] SIG;
    logic        MISMATCH;

    modport master (
        input  START, PAT_COUNT, GOLDEN_SIG, G17,
        output DUT_G0, DUT_G1, DUT_G2, DUT_G3, BUSY, DONE, SIG, MISMATCH
    );

    modport slave (
        output START, PAT_COUNT, GOLDEN_SIG, G17,
        input  DUT_G0, DUT_G1, DUT_G2, DUT_G3, BUSY, DONE, SIG, MISMATCH
    );
endinterface

// File: rtl/s27_bist_sequencer.sv
// s27_bist_sequencer
//   BIST controller for the s27 benchmark. Flushes the s27 flops with
//   FLUSH_CYC all-zero cycles, applies PAT_COUNT LFSR patterns on G0..G3,
//   compacts every G17 response into a 16-bit MISR and flags a mismatch
//   against the golden signature at the end of the run.
//
//   CK   clock, all state updates on posedge
//   RST  asynchronous active-high reset
//   bus  s27_bist_sequencer_if.master (START, PAT_COUNT, GOLDEN_SIG, G17 in;
//        DUT_G0..3, BUSY, DONE, SIG, MISMATCH out)
module s27_bist_sequencer #(
    parameter logic [7:0]  SEED      = 8'hA5,
    parameter int unsigned FLUSH_CYC = 4,
    parameter logic [15:0] SIG_INIT  = 16'hFFFF
) (
    input  logic                        CK,
    input  logic                        RST,
    s27_bist_sequencer_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYC - 1);

    state_t      r_state;
    logic [7:0]  r_lfsr;
    logic [15:0] r_sig;
    logic [15:0] r_golden;
    logic [15:0] r_pat_cnt;
    logic [15:0] r_idx;
    logic [3:0]  r_fcnt;
    logic [3:0]  r_dut_g;
    logic        r_busy;
    logic        r_done;
    logic        r_mismatch;

    logic [7:0]  w_lfsr_next;
    logic [15:0] w_misr_next;
    logic        w_last_pat;
    logic        w_last_flush;

    assign w_lfsr_next  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_misr_next  = {r_sig[14:0], 1'b0}
                        ^ (r_sig[15] ? 16'h1021 : 16'h0000)
                        ^ {15'b0, bus.G17};
    // PAT_COUNT is nonzero whenever RUN is entered, so the subtraction never
    // wraps and a count of 16'hFFFF runs the full 65535 patterns.
    assign w_last_pat   = (r_idx == (r_pat_cnt - 16'd1));
    assign w_last_flush = (r_fcnt == FLUSH_LAST);

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_lfsr     <= SEED;
            r_sig      <= SIG_INIT;
            r_golden   <= '0;
            r_pat_cnt  <= '0;
            r_idx      <= '0;
            r_fcnt     <= '0;
            r_dut_g    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dut_g <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (bus.START) begin
                        r_pat_cnt  <= bus.PAT_COUNT;
                        r_golden   <= bus.GOLDEN_SIG;
                        r_lfsr     <= SEED;
                        r_sig      <= SIG_INIT;
                        r_mismatch <= 1'b0;
                        r_idx      <= '0;
                        r_fcnt     <= '0;
                        if (bus.PAT_COUNT != 16'd0) begin
                            r_state <= S_FLUSH;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end

                S_FLUSH: begin
                    if (w_last_flush) begin
                        r_state <= S_RUN;
                        r_dut_g <= r_lfsr[3:0];
                    end else begin
                        r_fcnt <= r_fcnt + 4'd1;
                    end
                end

                S_RUN: begin
                    r_sig  <= w_misr_next;
                    r_lfsr <= w_lfsr_next;
                    if (w_last_pat) begin
                        r_state    <= S_FIN;
                        r_dut_g    <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_mismatch <= (w_misr_next != r_golden);
                    end else begin
                        r_idx   <= r_idx + 16'd1;
                        r_dut_g <= w_lfsr_next[3:0];
                    end
                end

                S_FIN: begin
                    // Arriving from RUN, DONE is already high and drops here.
                    // Arriving straight from IDLE (zero patterns), DONE rises
                    // here instead, so it lands one edge after START.
                    r_state <= S_IDLE;
                    r_done  <= ~r_done;
                    if (!r_done) begin
                        r_mismatch <= (r_sig != r_golden);
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.DUT_G0   = r_dut_g[0];
    assign bus.DUT_G1   = r_dut_g[1];
    assign bus.DUT_G2   = r_dut_g[2];
    assign bus.DUT_G3   = r_dut_g[3];
    assign bus.BUSY     = r_busy;
    assign bus.DONE     = r_done;
    assign bus.SIG      = r_sig;
    assign bus.MISMATCH = r_mismatch;

endmodule

// File: tb/tb_s27_bist_sequencer.sv
// tb_s27_bist_sequencer
//   Bench for s27_bist_sequencer: tied-G17 runs with hand-derived signatures,
//   stimulus ordering, zero-length runs, ignored START, mid-run reset, LFSR
//   wrap and closed-loop runs against a clean and a trojaned s27 model.
module tb_s27_bist_sequencer;

    typedef struct {
        logic [15:0] sig;
        logic        mm;
    } res_t;

    logic CK = 1'b0;
    logic RST;
    always #5 CK = ~CK;

    s27_bist_sequencer_if bif();

    s27_bist_sequencer #(
        .SEED      (8'hA5),
        .FLUSH_CYC (4),
        .SIG_INIT  (16'hFFFF)
    ) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bif.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] q_exp_g[$];
    logic [3:0] q_obs_g[$];
    res_t       q_exp_res[$];

    // s27 netlist; returns {G17, next G5, next G6, next G7}. st = {G5,G6,G7}.
    // The trojan flips G17 whenever all four inputs are high.
    function automatic logic [3:0] s27_eval(input logic [3:0] g, input logic [2:0] st, input logic troj);
        logic g14, g12, g8, g15, g16, g9, g11, g10, g13, g17;
        g14 = ~g[0];
        g12 = ~(g[1] | st[0]);
        g8  = g14 & st[1];
        g15 = g12 | g8;
        g16 = g[3] | g8;
        g9  = ~(g16 & g15);
        g11 = ~(st[2] | g9);
        g10 = ~(g14 | g11);
        g13 = ~(g[2] | g12);
        g17 = ~g11;
        if (troj && (g == 4'hF)) g17 = ~g17;
        return {g17, g10, g11, g13};
    endfunction

    // Live s27 instance model beside the DUT
    logic       r_use_s27 = 1'b0;
    logic       r_g17_tie = 1'b0;
    logic       r_troj    = 1'b0;
    logic [2:0] s27_st;
    logic [3:0] w_s27;

    assign w_s27   = s27_eval({bif.DUT_G3, bif.DUT_G2, bif.DUT_G1, bif.DUT_G0}, s27_st, r_troj);
    assign bif.G17 = r_use_s27 ? w_s27[3] : r_g17_tie;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) s27_st <= '0;
        else     s27_st <= w_s27[2:0];
    end

    // Reference: mode 0 = G17 tied 0, 1 = tied 1, 2 = clean s27, 3 = trojaned s27
    task automatic model_run(input int n, input int mode, input bit push, output logic [15:0] sig);
        logic [7:0] l;
        logic [2:0] st;
        logic [3:0] r;
        logic       b;
        l   = 8'hA5;
        st  = '0;
        sig = 16'hFFFF;
        if (n > 0) begin
            for (int i = 0; i < 4; i++) begin
                r  = s27_eval(4'h0, st, mode == 3);
                st = r[2:0];
                if (push) q_exp_g.push_back(4'h0);
            end
        end
        for (int k = 0; k < n; k++) begin
            r   = s27_eval(l[3:0], st, mode == 3);
            b   = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : r[3];
            sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {15'h0, b};
            st  = r[2:0];
            if (push) q_exp_g.push_back(l[3:0]);
            l   = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
    endtask

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    // Starts a run and records BUSY cycles, DONE position (edges after the
    // START edge) and the stimulus seen during BUSY. pulse_at >= 0 re-asserts
    // START and alters PAT_COUNT/GOLDEN_SIG mid-run.
    task automatic run_capture(input logic [15:0] pc, input logic [15:0] gold, input int pulse_at,
                               output int busy_n, output int done_k);
        bif.PAT_COUNT  = pc;
        bif.GOLDEN_SIG = gold;
        bif.START      = 1'b1;
        tick;
        bif.START = 1'b0;
        busy_n = 0;
        done_k = -1;
        q_obs_g.delete();
        for (int k = 0; k < 2000; k++) begin
            if (bif.DONE === 1'b1) begin
                done_k = k;
                break;
            end
            if (bif.BUSY === 1'b1) begin
                busy_n++;
                q_obs_g.push_back({bif.DUT_G3, bif.DUT_G2, bif.DUT_G1, bif.DUT_G0});
            end
            bif.START = (k == pulse_at);
            if (pulse_at >= 0 && k >= 1) begin
                bif.PAT_COUNT  = 16'd2;
                bif.GOLDEN_SIG = ~gold;
            end
            tick;
        end
        bif.START = 1'b0;
        if (done_k < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: DONE not seen within 2000 cycles, required by cycle %0d", 4 + pc);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        bif.START = 1'b0;
        bif.PAT_COUNT = '0;
        bif.GOLDEN_SIG = '0;
        #12 RST = 1'b0;
        repeat (10) tick;
        n_cmp++; if ({bif.DUT_G3, bif.DUT_G2, bif.DUT_G1, bif.DUT_G0} !== 4'h0) begin n_err++; $display("FAIL reset_dutg: got %h want 0", {bif.DUT_G3, bif.DUT_G2, bif.DUT_G1, bif.DUT_G0}); end
        n_cmp++; if (bif.BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bif.BUSY); end
        n_cmp++; if (bif.DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bif.DONE); end
        n_cmp++; if (bif.SIG !== 16'hFFFF) begin n_err++; $display("FAIL reset_sig: got %h want ffff", bif.SIG); end
        n_cmp++; if (bif.MISMATCH !== 1'b0) begin n_err++; $display("FAIL reset_mm: got %b want 0", bif.MISMATCH); end
    endtask

    // One pattern with G17 tied; signatures derived by hand from FFFF.
    task automatic test_single(input logic tie, input logic [15:0] exp_sig, input logic exp_mm);
        int busy_n, done_k;
        res_t r;
        logic [3:0] e, o;
        r_use_s27 = 1'b0;
        r_g17_tie = tie;
        for (int i = 0; i < 4; i++) q_exp_g.push_back(4'h0);
        q_exp_g.push_back(4'h5);
        q_exp_res.push_back('{exp_sig, exp_mm});
        run_capture(16'd1, 16'hEFDF, -1, busy_n, done_k);
        n_cmp++; if (busy_n !== 5) begin n_err++; $display("FAIL single%0d_busy: got %0d want 5", tie, busy_n); end
        n_cmp++; if (done_k !== 5) begin n_err++; $display("FAIL single%0d_latency: got %0d want 5", tie, done_k); end
        while (q_exp_g.size() > 0) begin
            e = q_exp_g.pop_front();
            o = (q_obs_g.size() > 0) ? q_obs_g.pop_front() : 4'hx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL single%0d_stim: got %h want %h", tie, o, e); end
        end
        r = q_exp_res.pop_front();
        n_cmp++; if (bif.SIG !== r.sig) begin n_err++; $display("FAIL single%0d_sig: got %h want %h", tie, bif.SIG, r.sig); end
        n_cmp++; if (bif.MISMATCH !== r.mm) begin n_err++; $display("FAIL single%0d_mm: got %b want %b", tie, bif.MISMATCH, r.mm); end
        tick;
        n_cmp++; if (bif.DONE !== 1'b0) begin n_err++; $display("FAIL single%0d_done_pulse: got %b want 0", tie, bif.DONE); end
        n_cmp++; if (bif.SIG !== r.sig) begin n_err++; $display("FAIL single%0d_sig_hold: got %h want %h", tie, bif.SIG, r.sig); end
    endtask

    // Three patterns: stimulus 5, A, 5 from LFSR states A5, 4A, 95.
    task automatic test_sequence;
        int busy_n, done_k;
        res_t r;
        logic [3:0] e, o;
        r_use_s27 = 1'b0;
        r_g17_tie = 1'b0;
        for (int i = 0; i < 4; i++) q_exp_g.push_back(4'h0);
        q_exp_g.push_back(4'h5);
        q_exp_g.push_back(4'hA);
        q_exp_g.push_back(4'h5);
        q_exp_res.push_back('{16'h8F1F, 1'b1});
        run_capture(16'd3, 16'h0000, -1, busy_n, done_k);
        n_cmp++; if (done_k !== 7) begin n_err++; $display("FAIL seq_latency: got %0d want 7", done_k); end
        while (q_exp_g.size() > 0) begin
            e = q_exp_g.pop_front();
            o = (q_obs_g.size() > 0) ? q_obs_g.pop_front() : 4'hx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL seq_stim: got %h want %h", o, e); end
        end
        r = q_exp_res.pop_front();
        n_cmp++; if (bif.SIG !== r.sig) begin n_err++; $display("FAIL seq_sig: got %h want %h", bif.SIG, r.sig); end
        n_cmp++; if (bif.MISMATCH !== r.mm) begin n_err++; $display("FAIL seq_mm: got %b want %b", bif.MISMATCH, r.mm); end
        tick;
    endtask

    task automatic test_zero(input logic [15:0] gold, input logic exp_mm);
        int busy_n, done_k;
        res_t r;
        q_exp_res.push_back('{16'hFFFF, exp_mm});
        run_capture(16'd0, gold, -1, busy_n, done_k);
        n_cmp++; if (done_k !== 1) begin n_err++; $display("FAIL zero_latency: got %0d want 1", done_k); end
        n_cmp++; if (busy_n !== 0) begin n_err++; $display("FAIL zero_busy: got %0d want 0", busy_n); end
        r = q_exp_res.pop_front();
        n_cmp++; if (bif.SIG !== r.sig) begin n_err++; $display("FAIL zero_sig: got %h want %h", bif.SIG, r.sig); end
        n_cmp++; if (bif.MISMATCH !== r.mm) begin n_err++; $display("FAIL zero_mm: got %b want %b", bif.MISMATCH, r.mm); end
        tick;
        n_cmp++; if (bif.DONE !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse: got %b want 0", bif.DONE); end
    endtask

    // Generic modelled run: mode selects the G17 source, pulse_at disturbs it.
    task automatic test_model_run(input string tag, input int n, input int mode, input int pulse_at);
        int busy_n, done_k;
        res_t r;
        logic [15:0] clean_sig, act_sig;
        logic [3:0] e, o;
        r_use_s27 = (mode >= 2);
        r_troj    = (mode == 3);
        r_g17_tie = (mode == 1);
        model_run(n, (mode == 3) ? 2 : mode, 1'b0, clean_sig);
        model_run(n, mode, 1'b1, act_sig);
        q_exp_res.push_back('{act_sig, act_sig != clean_sig});
        run_capture(n[15:0], clean_sig, pulse_at, busy_n, done_k);
        n_cmp++; if (done_k !== 4 + n) begin n_err++; $display("FAIL %s_latency: got %0d want %0d", tag, done_k, 4 + n); end
        n_cmp++; if (busy_n !== 4 + n) begin n_err++; $display("FAIL %s_busy: got %0d want %0d", tag, busy_n, 4 + n); end
        while (q_exp_g.size() > 0) begin
            e = q_exp_g.pop_front();
            o = (q_obs_g.size() > 0) ? q_obs_g.pop_front() : 4'hx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL %s_stim: got %h want %h", tag, o, e); end
        end
        r = q_exp_res.pop_front();
        n_cmp++; if (bif.SIG !== r.sig) begin n_err++; $display("FAIL %s_sig: got %h want %h", tag, bif.SIG, r.sig); end
        n_cmp++; if (bif.MISMATCH !== r.mm) begin n_err++; $display("FAIL %s_mm: got %b want %b", tag, bif.MISMATCH, r.mm); end
        tick;
        r_use_s27 = 1'b0;
        r_troj    = 1'b0;
    endtask

    task automatic test_rst_mid_run;
        bif.PAT_COUNT  = 16'd10;
        bif.GOLDEN_SIG = 16'h1234;
        r_use_s27 = 1'b0;
        r_g17_tie = 1'b1;
        bif.START = 1'b1;
        tick;
        bif.START = 1'b0;
        repeat (6) tick;
        n_cmp++; if (bif.BUSY !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy: got %b want 1", bif.BUSY); end
        #2 RST = 1'b1;
        #1;
        n_cmp++; if ({bif.DUT_G3, bif.DUT_G2, bif.DUT_G1, bif.DUT_G0} !== 4'h0) begin n_err++; $display("FAIL rst_dutg: got %h want 0", {bif.DUT_G3, bif.DUT_G2, bif.DUT_G1, bif.DUT_G0}); end
        n_cmp++; if (bif.BUSY !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bif.BUSY); end
        n_cmp++; if (bif.DONE !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", bif.DONE); end
        n_cmp++; if (bif.SIG !== 16'hFFFF) begin n_err++; $display("FAIL rst_sig: got %h want ffff", bif.SIG); end
        n_cmp++; if (bif.MISMATCH !== 1'b0) begin n_err++; $display("FAIL rst_mm: got %b want 0", bif.MISMATCH); end
        #2 RST = 1'b0;
        tick;
        test_model_run("rst_rerun", 10, 1, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single(1'b0, 16'hEFDF, 1'b0);
        test_single(1'b1, 16'hEFDE, 1'b1);
        test_sequence();
        test_zero(16'hFFFF, 1'b0);
        test_zero(16'h1234, 1'b1);
        test_model_run("start_ignored", 5, 1, 5);
        test_rst_mid_run();
        test_model_run("lfsr_wrap", 300, 0, -1);
        RST = 1'b1;
        #3 RST = 1'b0;
        tick;
        test_model_run("s27_clean", 256, 2, -1);
        RST = 1'b1;
        #3 RST = 1'b0;
        tick;
        test_model_run("s27_trojan", 256, 3, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
